// File: rtl/instruction_decode.sv
// -----------------------------------------------------------------------------
// instruction_decode
//
// Single-entry RV32I decode stage sitting directly in front of the register
// file. Fetched instructions arrive over a valid/ready handshake and are
// decoded into one registered output slot holding register indices and
// enables, the sign-extended immediate, the operation class and the funct
// pass-through fields. The slot's rs1/rs2 index and enable outputs drive the
// register file read ports directly, so operand data is valid in the same
// cycle as the bundle.
//
// Optional feature (macro DECODE_SCOREBOARD_EN):
//   defined   - a busy-bit scoreboard interlocks read-after-write hazards
//               against writes that have not yet reached the register file
//               write port (wbAddr_In / wbEnable_In).
//   undefined - no scoreboard; decValid_Out follows slot occupancy and the
//               write-port inputs are ignored.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   instValid_In      fetch offers an instruction
//   instReady_Out     decode can accept this cycle
//   inst_In, pc_In    instruction word and its address
//   flush_In          discard held and incoming instruction
//   decValid_Out      decoded bundle valid and hazard-free
//   decReady_In       execute accepts bundle
//   pc_Out            PC of the held instruction
//   rs1Addr_Out, rs2Addr_Out, rs1Enable_Out, rs2Enable_Out
//                     register file read indices and enables
//   rdAddr_Out, rdEnable_Out
//                     destination index, write enable (0 when rd = x0)
//   imm_Out           sign-extended immediate
//   opClass_Out       operation class
//   funct3_Out, funct7b5_Out
//                     pass-through instruction fields
//   wbAddr_In, wbEnable_In
//                     copy of the register file write port
// -----------------------------------------------------------------------------
module instruction_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic        instValid_In,
    output logic        instReady_Out,
    input  logic [31:0] inst_In,
    input  logic [31:0] pc_In,
    input  logic        flush_In,
    output logic        decValid_Out,
    input  logic        decReady_In,
    output logic [31:0] pc_Out,
    output logic [4:0]  rs1Addr_Out,
    output logic [4:0]  rs2Addr_Out,
    output logic        rs1Enable_Out,
    output logic        rs2Enable_Out,
    output logic [4:0]  rdAddr_Out,
    output logic        rdEnable_Out,
    output logic [31:0] imm_Out,
    output logic [3:0]  opClass_Out,
    output logic [2:0]  funct3_Out,
    output logic        funct7b5_Out,
    input  logic [4:0]  wbAddr_In,
    input  logic        wbEnable_In
);

    typedef enum logic [3:0] {
        CLS_LUI      = 4'd0,
        CLS_AUIPC    = 4'd1,
        CLS_JAL      = 4'd2,
        CLS_JALR     = 4'd3,
        CLS_BRANCH   = 4'd4,
        CLS_LOAD     = 4'd5,
        CLS_STORE    = 4'd6,
        CLS_OP_IMM   = 4'd7,
        CLS_OP       = 4'd8,
        CLS_MISC_MEM = 4'd9,
        CLS_SYSTEM   = 4'd10,
        CLS_ILLEGAL  = 4'd15
    } op_class_e;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_HELD
    } slot_state_e;

    // -------------------------------------------------------------------------
    // Handshake and slot state
    // -------------------------------------------------------------------------
    slot_state_e state;
    slot_state_e state_next;

    logic held;
    logic hazard;
    logic fire_in;
    logic fire_out;
    logic load_slot;

    assign held          = (state == SLOT_HELD);
    assign decValid_Out  = held & ~hazard;
    assign fire_out      = decValid_Out & decReady_In;
    assign instReady_Out = ~rst & (~held | fire_out);
    assign fire_in       = instValid_In & instReady_Out;
    // A flush wins over an incoming instruction in the same cycle.
    assign load_slot     = fire_in & ~flush_In;

    always_ff @(posedge clk) begin
        // NOTE: state elements use non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_next = state;
        if (flush_In) begin
            state_next = SLOT_EMPTY;
        end else if (fire_in) begin
            // Covers the simultaneous drain-and-reload case: stays HELD.
            state_next = SLOT_HELD;
        end else if (fire_out) begin
            state_next = SLOT_EMPTY;
        end
    end

    // -------------------------------------------------------------------------
    // Combinational decode of the incoming word
    // -------------------------------------------------------------------------
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{inst_In[31]}}, inst_In[31:20]};
    assign imm_s = {{20{inst_In[31]}}, inst_In[31:25], inst_In[11:7]};
    assign imm_b = {{19{inst_In[31]}}, inst_In[31], inst_In[7],
                    inst_In[30:25], inst_In[11:8], 1'b0};
    assign imm_u = {inst_In[31:12], 12'h000};
    assign imm_j = {{11{inst_In[31]}}, inst_In[31], inst_In[19:12],
                    inst_In[20], inst_In[30:21], 1'b0};

    op_class_e   dec_class;
    logic        dec_rs1_en;
    logic        dec_rs2_en;
    logic        dec_rd_wr;
    logic        dec_rd_en;
    logic [31:0] dec_imm;

    always_comb begin
        dec_class  = CLS_ILLEGAL;
        dec_rs1_en = 1'b0;
        dec_rs2_en = 1'b0;
        dec_rd_wr  = 1'b0;
        dec_imm    = '0;
        // Compressed or otherwise malformed low bits stay ILLEGAL with all
        // enables off; the bundle is still delivered so execute can trap.
        if (inst_In[1:0] == 2'b11) begin
            case (inst_In[6:2])
                5'b01101: begin
                    dec_class = CLS_LUI;
                    dec_rd_wr = 1'b1;
                    dec_imm   = imm_u;
                end
                5'b00101: begin
                    dec_class = CLS_AUIPC;
                    dec_rd_wr = 1'b1;
                    dec_imm   = imm_u;
                end
                5'b11011: begin
                    dec_class = CLS_JAL;
                    dec_rd_wr = 1'b1;
                    dec_imm   = imm_j;
                end
                5'b11001: begin
                    dec_class  = CLS_JALR;
                    dec_rs1_en = 1'b1;
                    dec_rd_wr  = 1'b1;
                    dec_imm    = imm_i;
                end
                5'b11000: begin
                    dec_class  = CLS_BRANCH;
                    dec_rs1_en = 1'b1;
                    dec_rs2_en = 1'b1;
                    dec_imm    = imm_b;
                end
                5'b00000: begin
                    dec_class  = CLS_LOAD;
                    dec_rs1_en = 1'b1;
                    dec_rd_wr  = 1'b1;
                    dec_imm    = imm_i;
                end
                5'b01000: begin
                    dec_class  = CLS_STORE;
                    dec_rs1_en = 1'b1;
                    dec_rs2_en = 1'b1;
                    dec_imm    = imm_s;
                end
                5'b00100: begin
                    dec_class  = CLS_OP_IMM;
                    dec_rs1_en = 1'b1;
                    dec_rd_wr  = 1'b1;
                    dec_imm    = imm_i;
                end
                5'b01100: begin
                    dec_class  = CLS_OP;
                    dec_rs1_en = 1'b1;
                    dec_rs2_en = 1'b1;
                    dec_rd_wr  = 1'b1;
                end
                5'b00011: dec_class = CLS_MISC_MEM;
                5'b11100: dec_class = CLS_SYSTEM;
                default:  dec_class = CLS_ILLEGAL;
            endcase
        end
        // x0 is never written, so it must never mark a register busy.
        dec_rd_en = dec_rd_wr & (inst_In[11:7] != 5'd0);
    end

    // -------------------------------------------------------------------------
    // Output slot
    // -------------------------------------------------------------------------
    logic [31:0] pc_q;
    logic [4:0]  rs1_addr_q;
    logic [4:0]  rs2_addr_q;
    logic        rs1_en_q;
    logic        rs2_en_q;
    logic [4:0]  rd_addr_q;
    logic        rd_en_q;
    logic [31:0] imm_q;
    logic [3:0]  class_q;
    logic [2:0]  funct3_q;
    logic        funct7b5_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rs1_en_q   <= 1'b0;
            rs2_en_q   <= 1'b0;
            rd_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            imm_q      <= '0;
            class_q    <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
        end else if (load_slot) begin
            pc_q       <= pc_In;
            rs1_addr_q <= inst_In[19:15];
            rs2_addr_q <= inst_In[24:20];
            rs1_en_q   <= dec_rs1_en;
            rs2_en_q   <= dec_rs2_en;
            rd_addr_q  <= inst_In[11:7];
            rd_en_q    <= dec_rd_en;
            imm_q      <= dec_imm;
            class_q    <= dec_class;
            funct3_q   <= inst_In[14:12];
            funct7b5_q <= inst_In[30];
        end
    end

    assign pc_Out       = pc_q;
    assign rs1Addr_Out  = rs1_addr_q;
    assign rs2Addr_Out  = rs2_addr_q;
    assign rdAddr_Out   = rd_addr_q;
    assign imm_Out      = imm_q;
    assign opClass_Out  = class_q;
    assign funct3_Out   = funct3_q;
    assign funct7b5_Out = funct7b5_q;

    // Enables are gated by occupancy so an empty slot reads zeros from the
    // register file and never requests a write.
    assign rs1Enable_Out = held & rs1_en_q;
    assign rs2Enable_Out = held & rs2_en_q;
    assign rdEnable_Out  = held & rd_en_q;

    // -------------------------------------------------------------------------
    // Read-after-write scoreboard
    // -------------------------------------------------------------------------
`ifdef DECODE_SCOREBOARD_EN
    logic [31:1] busy;
    logic [31:0] busy_idx;

    // x0 is hardwired not-busy so the read index can address bit 0 directly.
    assign busy_idx = {busy, 1'b0};

    always_ff @(posedge clk) begin
        // NOTE: the busy bits are a small flop array, not a RAM, and must be
        // reset: a stale busy bit after reset would deadlock the interlock.
        if (rst) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                // Issue of a new writer wins over retirement of the old one.
                if (fire_out && rdEnable_Out && (rdAddr_Out == 5'(i))) begin
                    busy[i] <= 1'b1;
                end else if (wbEnable_In && (wbAddr_In == 5'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    // Only source operands interlock; writeback is in order, so a busy rd
    // alone is harmless.
    assign hazard = (rs1Enable_Out & busy_idx[rs1Addr_Out])
                  | (rs2Enable_Out & busy_idx[rs2Addr_Out]);
`else
    // Hazards are resolved elsewhere; the write-port copy is not needed.
    logic unused_wb;
    assign unused_wb = &{1'b0, wbAddr_In, wbEnable_In};
    assign hazard    = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_decode.sv
module tb_instruction_decode;

`ifdef DECODE_SCOREBOARD_EN
    localparam logic SB_EN = 1'b1;
`else
    localparam logic SB_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        instValid_In;
    logic        instReady_Out;
    logic [31:0] inst_In;
    logic [31:0] pc_In;
    logic        flush_In;
    logic        decValid_Out;
    logic        decReady_In;
    logic [31:0] pc_Out;
    logic [4:0]  rs1Addr_Out;
    logic [4:0]  rs2Addr_Out;
    logic        rs1Enable_Out;
    logic        rs2Enable_Out;
    logic [4:0]  rdAddr_Out;
    logic        rdEnable_Out;
    logic [31:0] imm_Out;
    logic [3:0]  opClass_Out;
    logic [2:0]  funct3_Out;
    logic        funct7b5_Out;
    logic [4:0]  wbAddr_In;
    logic        wbEnable_In;

    instruction_decode dut (
        .clk          (clk),
        .rst          (rst),
        .instValid_In (instValid_In),
        .instReady_Out(instReady_Out),
        .inst_In      (inst_In),
        .pc_In        (pc_In),
        .flush_In     (flush_In),
        .decValid_Out (decValid_Out),
        .decReady_In  (decReady_In),
        .pc_Out       (pc_Out),
        .rs1Addr_Out  (rs1Addr_Out),
        .rs2Addr_Out  (rs2Addr_Out),
        .rs1Enable_Out(rs1Enable_Out),
        .rs2Enable_Out(rs2Enable_Out),
        .rdAddr_Out   (rdAddr_Out),
        .rdEnable_Out (rdEnable_Out),
        .imm_Out      (imm_Out),
        .opClass_Out  (opClass_Out),
        .funct3_Out   (funct3_Out),
        .funct7b5_Out (funct7b5_Out),
        .wbAddr_In    (wbAddr_In),
        .wbEnable_In  (wbEnable_In)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  cls;
        logic [4:0]  rd;
        logic        rd_en;
        logic [4:0]  rs1;
        logic        rs1_en;
        logic [4:0]  rs2;
        logic        rs2_en;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic        f7b5;
    } bundle_t;

    bundle_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bundle_t mk(input logic [31:0] pc, input logic [3:0] cls,
                                   input logic [4:0] rd, input logic rd_en,
                                   input logic [4:0] rs1, input logic rs1_en,
                                   input logic [4:0] rs2, input logic rs2_en,
                                   input logic [31:0] imm, input logic [2:0] f3,
                                   input logic f7b5);
        bundle_t b;
        b.pc = pc; b.cls = cls; b.rd = rd; b.rd_en = rd_en;
        b.rs1 = rs1; b.rs1_en = rs1_en; b.rs2 = rs2; b.rs2_en = rs2_en;
        b.imm = imm; b.f3 = f3; b.f7b5 = f7b5;
        return b;
    endfunction

    // Monitor: every delivered bundle is matched against the oldest expected.
    always @(negedge clk) begin
        if (!rst && decValid_Out && decReady_In) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_bundle: got pc 0x%08h expected none at %0t",
                         pc_Out, $time);
            end else begin
                bundle_t e;
                e = exp_q.pop_front();
                check("bundle_pc",       pc_Out,                e.pc);
                check("bundle_class",    32'(opClass_Out),      32'(e.cls));
                check("bundle_rd",       32'(rdAddr_Out),       32'(e.rd));
                check("bundle_rd_en",    32'(rdEnable_Out),     32'(e.rd_en));
                check("bundle_rs1",      32'(rs1Addr_Out),      32'(e.rs1));
                check("bundle_rs1_en",   32'(rs1Enable_Out),    32'(e.rs1_en));
                check("bundle_rs2",      32'(rs2Addr_Out),      32'(e.rs2));
                check("bundle_rs2_en",   32'(rs2Enable_Out),    32'(e.rs2_en));
                check("bundle_imm",      imm_Out,               e.imm);
                check("bundle_funct3",   32'(funct3_Out),       32'(e.f3));
                check("bundle_funct7b5", 32'(funct7b5_Out),     32'(e.f7b5));
            end
        end
    end

    // Offer one instruction starting now (just after a posedge); returns just
    // after the accepting edge. 'waited' counts cycles spent not ready.
    task automatic send(input logic [31:0] inst, input logic [31:0] pc,
                        input logic push, input bundle_t e, output int waited);
        instValid_In = 1'b1;
        inst_In      = inst;
        pc_In        = pc;
        waited       = 0;
        forever begin
            @(negedge clk);
            if (instReady_Out) begin
                if (push) exp_q.push_back(e);
                break;
            end
            waited++;
            if (waited > 20) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: got no ready after %0d cycles expected ready, pc 0x%08h",
                         waited, pc);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        instValid_In = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1; instValid_In = 1'b0; inst_In = '0; pc_In = '0;
        flush_In = 1'b0; decReady_In = 1'b1; wbAddr_In = '0; wbEnable_In = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_inst_ready", 32'(instReady_Out), 32'd0);
        check("rst_dec_valid",  32'(decValid_Out),  32'd0);
        check("rst_pc",         pc_Out,             32'd0);
        check("rst_imm",        imm_Out,            32'd0);
        check("rst_class",      32'(opClass_Out),   32'd0);
        check("rst_rd_en",      32'(rdEnable_Out),  32'd0);
        check("rst_rs1_en",     32'(rs1Enable_Out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(instReady_Out), 32'd1);
        @(posedge clk); #1;

        // addi x5,x0,-1 then add x6,x5,x5 (RAW on x5)
        send(32'hFFF00293, 32'h100, 1'b1,
             mk(32'h100, 4'd7, 5'd5, 1'b1, 5'd0, 1'b1, 5'd31, 1'b0, 32'hFFFFFFFF, 3'd0, 1'b1), w);
        send(32'h00528333, 32'h104, 1'b1,
             mk(32'h104, 4'd8, 5'd6, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 32'h0, 3'd0, 1'b0), w);
        check("raw_accept_wait", 32'(w), 32'd0);
        @(negedge clk);
        check("raw_stall_valid", 32'(decValid_Out), 32'(!SB_EN));
        @(posedge clk); #1;
        wbEnable_In = 1'b1; wbAddr_In = 5'd5;
        @(negedge clk);
        check("raw_wb_cycle_valid", 32'(decValid_Out), 32'd0);
        @(posedge clk); #1;
        wbEnable_In = 1'b0; wbAddr_In = 5'd0;
        @(negedge clk);
        check("raw_release_valid", 32'(decValid_Out), 32'(SB_EN));
        @(posedge clk); #1;

        // Back-to-back independent instructions, then an all-zero word
        send(32'hFE712E23, 32'h200, 1'b1,
             mk(32'h200, 4'd6, 5'd28, 1'b0, 5'd2, 1'b1, 5'd7, 1'b1, 32'hFFFFFFFC, 3'd2, 1'b1), w);
        check("b2b_wait_sw", 32'(w), 32'd0);
        send(32'hFE208CE3, 32'h204, 1'b1,
             mk(32'h204, 4'd4, 5'd25, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 32'hFFFFFFF8, 3'd0, 1'b1), w);
        check("b2b_wait_beq", 32'(w), 32'd0);
        send(32'h123450B7, 32'h208, 1'b1,
             mk(32'h208, 4'd0, 5'd1, 1'b1, 5'd8, 1'b0, 5'd3, 1'b0, 32'h12345000, 3'd5, 1'b0), w);
        check("b2b_wait_lui", 32'(w), 32'd0);
        send(32'h80000117, 32'h20C, 1'b1,
             mk(32'h20C, 4'd1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h80000000, 3'd0, 1'b0), w);
        check("b2b_wait_auipc", 32'(w), 32'd0);
        send(32'h001000EF, 32'h210, 1'b1,
             mk(32'h210, 4'd2, 5'd1, 1'b1, 5'd0, 1'b0, 5'd1, 1'b0, 32'h00000800, 3'd0, 1'b0), w);
        check("b2b_wait_jal", 32'(w), 32'd0);
        send(32'h00000000, 32'h214, 1'b1,
             mk(32'h214, 4'd15, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0, 3'd0, 1'b0), w);
        check("b2b_wait_illegal", 32'(w), 32'd0);
        @(negedge clk);
        check("illegal_valid", 32'(decValid_Out), 32'd1);
        @(posedge clk); #1;

        // Downstream stall for three cycles, then flush
        decReady_In = 1'b0;
        send(32'h7FF18493, 32'h280, 1'b0, '0, w);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_valid", 32'(decValid_Out),  32'd1);
            check("stall_ready", 32'(instReady_Out), 32'd0);
            check("stall_imm",   imm_Out,            32'h000007FF);
            check("stall_rd",    32'(rdAddr_Out),    32'd9);
            check("stall_pc",    pc_Out,             32'h280);
            @(posedge clk); #1;
        end
        flush_In = 1'b1;
        @(posedge clk); #1;
        flush_In = 1'b0;
        @(negedge clk);
        check("flush_valid",  32'(decValid_Out),  32'd0);
        check("flush_rs1_en", 32'(rs1Enable_Out), 32'd0);
        check("flush_rs2_en", 32'(rs2Enable_Out), 32'd0);
        check("flush_rd_en",  32'(rdEnable_Out),  32'd0);
        check("flush_ready",  32'(instReady_Out), 32'd1);
        @(posedge clk); #1;

        // Flush drops a same-cycle incoming instruction
        flush_In = 1'b1; instValid_In = 1'b1; inst_In = 32'h000003B3; pc_In = 32'h284;
        @(negedge clk);
        check("flush_in_ready", 32'(instReady_Out), 32'd1);
        @(posedge clk); #1;
        flush_In = 1'b0; instValid_In = 1'b0;
        @(negedge clk);
        check("flush_drop_valid", 32'(decValid_Out), 32'd0);
        check("flush_drop_rd_en", 32'(rdEnable_Out), 32'd0);
        @(posedge clk); #1;

        // Reset asserted while a bundle is stalled
        send(32'h7FF18493, 32'h290, 1'b0, '0, w);
        @(negedge clk);
        check("pre_rst_valid", 32'(decValid_Out), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 32'(instReady_Out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(decValid_Out),  32'd0);
        check("mid_rst_pc",    pc_Out,             32'd0);
        check("mid_rst_imm",   imm_Out,            32'd0);
        check("mid_rst_rd_en", 32'(rdEnable_Out),  32'd0);
        check("mid_rst_ready", 32'(instReady_Out), 32'd1);
        @(posedge clk); #1;
        decReady_In = 1'b1;

        // addi x0,x1,1 (no write) followed by a read of x0
        send(32'h00108013, 32'h300, 1'b1,
             mk(32'h300, 4'd7, 5'd0, 1'b0, 5'd1, 1'b1, 5'd1, 1'b0, 32'h1, 3'd0, 1'b0), w);
        send(32'h000003B3, 32'h304, 1'b1,
             mk(32'h304, 4'd8, 5'd7, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 32'h0, 3'd0, 1'b0), w);
        check("x0_accept_wait", 32'(w), 32'd0);
        @(negedge clk);
        check("x0_read_valid", 32'(decValid_Out), 32'd1);
        @(posedge clk); #1;

        // Drain
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
# instruction_decode

Single-entry RV32I decode stage directly upstream of the register file. Accepts fetched instructions over a valid/ready handshake, and registers a decoded bundle (register indices and enables, sign-extended immediate, operation class) in one output slot. The slot's rs1/rs2 index and enable outputs drive the register file's read ports directly, so operand data is valid alongside the bundle. An optional scoreboard interlocks read-after-write hazards against writes that have not yet reached the register file's write port.

## Interface
- No parameters; datapath fixed at 32 bits, 32 architectural registers.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- instValid_In  in  1  fetch offers an instruction
- instReady_Out  out  1  decode can accept this cycle
- inst_In  in  32  instruction word
- pc_In  in  32  instruction address
- flush_In  in  1  discard held and incoming instruction
- decValid_Out  out  1  decoded bundle valid and hazard-free
- decReady_In  in  1  execute accepts bundle
- pc_Out  out  32  PC of held instruction
- rs1Addr_Out / rs2Addr_Out  out  5  register file read indices
- rs1Enable_Out / rs2Enable_Out  out  1  register file read enables
- rdAddr_Out  out  5  destination index
- rdEnable_Out  out  1  instruction writes rd (0 when rd = x0)
- imm_Out  out  32  sign-extended immediate
- opClass_Out  out  4  operation class (encoding below)
- funct3_Out  out  3  / funct7b5_Out  out  1  pass-through fields
- wbAddr_In  in  5  / wbEnable_In  in  1  copy of register file write port (rd index and enable)

## Operation
- Slot states: EMPTY, HELD. Fire_in = instValid_In & instReady_Out; fire_out = decValid_Out & decReady_In.
- instReady_Out = !rst & (EMPTY | fire_out). Same-cycle fire_out and fire_in: slot reloads, stays HELD.
- opClass: LUI 0, AUIPC 1, JAL 2, JALR 3, BRANCH 4, LOAD 5, STORE 6, OP-IMM 7, OP 8, MISC-MEM 9, SYSTEM 10, ILLEGAL 15.
- ILLEGAL: unknown opcode[6:2] or opcode[1:0] != 2'b11. Forces all enables to 0 and imm to 0; still delivered downstream.
- Immediates: I (JALR, LOAD, OP-IMM), S (STORE), B (BRANCH), U (LUI, AUIPC), J (JAL); all sign-extended from inst[31]. Other classes: 0.
- rs1Enable: JALR, BRANCH, LOAD, STORE, OP-IMM, OP. rs2Enable: BRANCH, STORE, OP. rdEnable: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and only when rd != 0.
- EMPTY slot: all enables 0, so register file outputs read 0.
- Scoreboard: busy[31:1] bits.
  - Set busy[rd] on fire_out when rdEnable_Out.
  - Clear busy[wbAddr_In] when wbEnable_In and wbAddr_In != 0.
  - Same-cycle set and clear of the same index: set wins.
- hazard = (rs1Enable_Out & busy[rs1Addr_Out]) | (rs2Enable_Out & busy[rs2Addr_Out]). decValid_Out = HELD & !hazard. A busy rd alone does not stall (in-order writeback).
- flush_In: slot becomes EMPTY next cycle, and any same-cycle fire_in is dropped. busy bits are unaffected, because in-flight writes still complete.

## Timing
- Reset: slot EMPTY, all busy bits 0, every output 0 (instReady_Out 0 while rst high, 1 in the first cycle after).
- Latency: instruction accepted at edge N appears on outputs in cycle N+1. Throughput is 1 per cycle with no hazards.
- Register file is written at edge T when wbEnable_In is high in cycle T. The matching busy bit clears at the same edge, so a stalled consumer asserts decValid_Out in cycle T+1 and reads the new value. There is no bypass.
- Held outputs are stable while decValid_Out & !decReady_In.
- rst asserted mid-stall: slot and scoreboard are cleared at that edge.

## Configuration
- DECODE_SCOREBOARD_EN defined: scoreboard and interlock as above.
- Undefined: no busy bits; decValid_Out = HELD. wbAddr_In and wbEnable_In are ignored; hazards are resolved elsewhere.

## Test plan
- addi x5,x0,-1 (0xFFF00293) then downstream ready -> next cycle opClass 7, rdAddr 5, rdEnable 1, rs1Enable 1, rs2Enable 0, imm 0xFFFFFFFF.
- addi x5 fires, then add x6,x5,x5 held -> decValid_Out 0. When wbEnable_In=1 and wbAddr_In=5 in cycle T -> decValid_Out 1 in T+1.
- Back-to-back independent instructions with decReady_In held 1 -> one bundle per cycle, instReady_Out stays 1.
- Word 0x00000000 -> opClass 15, all enables 0, imm 0, decValid_Out 1.
- decReady_In 0 for 3 cycles with bundle held -> outputs unchanged, instReady_Out 0. flush_In then -> next cycle decValid_Out 0, all enables 0.
- addi x0,x1,1 fires -> rdEnable_Out 0 and no busy bit set. A following read of x0 does not stall.
